mod_mul_p: RTL and testbench

MOD_MUL_P -- requirements
Module: mod_mul_p

---
 rtl/sm2_pkg.sv | 20 ++
 rtl/mod_mul_step.sv | 41 ++++
 rtl/mod_mul_p.sv | 130 +++++++++++++
 tb/tb_mod_mul_p.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm2_pkg.sv
// SM2 prime-field constants and types shared by mod_mul_p and mod_inv_p.
package sm2_pkg;

   localparam int unsigned SM2_WIDTH = 256;

   localparam logic [SM2_WIDTH-1:0] SM2_P =
      256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REDUCE,
      ST_RUN,
      ST_DONE
   } mul_state_t;

   function automatic int unsigned cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/mod_mul_step.sv
// One MSB-first interleaved modular multiply step:
// acc' = (2*acc mod P) [+ a, mod P when bit is set].
module mod_mul_step
   import sm2_pkg::*;
#(
   parameter int unsigned      WIDTH = SM2_WIDTH,
   parameter logic [WIDTH-1:0] P     = SM2_P
)(
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_a,
   input  logic             i_bit,
   output logic [WIDTH-1:0] o_acc
);

   logic [WIDTH:0]   w_p_ext;
   logic [WIDTH:0]   w_dbl;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_dbl_red;
   logic [WIDTH-1:0] w_sum_red;

   assign w_p_ext = {1'b0, P};

   // acc < P keeps both sums below 2P, so one subtraction is enough
   assign w_dbl = {i_acc, 1'b0};
   assign w_dbl_red = (w_dbl >= w_p_ext) ?
                      WIDTH'(w_dbl - w_p_ext) :
                      w_dbl[WIDTH-1:0];

   assign w_sum = {1'b0, w_dbl_red} + {1'b0, i_a};
   assign w_sum_red = (w_sum >= w_p_ext) ?
                      WIDTH'(w_sum - w_p_ext) :
                      w_sum[WIDTH-1:0];

   always_comb begin
      o_acc = w_dbl_red;
      if (i_bit) begin
         o_acc = w_sum_red;
      end
   end

endmodule

// File: rtl/mod_mul_p.sv
// Bit-serial modular multiplier out_c = in_a*in_b mod P, WIDTH+2 cycles.
// Define MOD_MUL_P_BUSY_EN to add the busy output.
module mod_mul_p
   import sm2_pkg::*;
#(
   parameter int unsigned      WIDTH = SM2_WIDTH,
   parameter logic [WIDTH-1:0] P     = SM2_P
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             datain,
   output logic [WIDTH-1:0] out_c,
   output logic             done
`ifdef MOD_MUL_P_BUSY_EN
   ,
   output logic             busy
`endif
);

   localparam int unsigned   CW      = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

   mul_state_t       r_state;
   mul_state_t       w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_out;
   logic [CW-1:0]    r_cnt;
   logic             r_done;

   logic [WIDTH-1:0] w_a_red;
   logic [WIDTH-1:0] w_b_red;
   logic [WIDTH-1:0] w_step;
   logic             w_bit;
   logic             w_last;

   // P > 2^(WIDTH-1), so any WIDTH-bit value needs at most one subtraction
   assign w_a_red = (r_a >= P) ? (r_a - P) : r_a;
   assign w_b_red = (r_b >= P) ? (r_b - P) : r_b;

   assign w_bit  = r_b[r_cnt];
   assign w_last = (r_cnt == '0);

   mod_mul_step #(
      .WIDTH (WIDTH),
      .P     (P)
   ) u_step (
      .i_acc (r_acc),
      .i_a   (r_a),
      .i_bit (w_bit),
      .o_acc (w_step)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (datain) begin
               w_state_nxt = ST_REDUCE;
            end
         end
         ST_REDUCE: w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_out  <= '0;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (datain) begin
                  r_a <= in_a;
                  r_b <= in_b;
               end
            end
            ST_REDUCE: begin
               r_a   <= w_a_red;
               r_b   <= w_b_red;
               r_acc <= '0;
               r_cnt <= CNT_TOP;
            end
            ST_RUN: begin
               r_acc <= w_step;
               r_cnt <= r_cnt - 1'b1;
               if (w_last) begin
                  r_out  <= w_step;
                  r_done <= 1'b1;
               end
            end
            ST_DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign out_c = r_out;
   assign done  = r_done;

`ifdef MOD_MUL_P_BUSY_EN
   assign busy = (r_state != ST_IDLE);
`endif

endmodule

// File: tb/tb_mod_mul_p.sv
// Self-checking bench for mod_mul_p: vector table, timing, abort and
// random cross-checks against a wide-arithmetic reference.
module tb_mod_mul_p;

   localparam int unsigned W = 256;
   localparam logic [W-1:0] P =
      256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
   localparam logic [W-1:0] MAXR =
      256'h0000000100000000000000000000000000000000FFFFFFFF0000000000000000;

   logic         clk    = 1'b0;
   logic         rstn   = 1'b0;
   logic         datain = 1'b0;
   logic [W-1:0] in_a   = '0;
   logic [W-1:0] in_b   = '0;
   logic [W-1:0] out_c;
   logic         done;
`ifdef MOD_MUL_P_BUSY_EN
   logic         busy;
`endif

   always #5 clk = ~clk;

   mod_mul_p dut (
      .clk    (clk),
      .rstn   (rstn),
      .in_a   (in_a),
      .in_b   (in_b),
      .datain (datain),
      .out_c  (out_c),
      .done   (done)
`ifdef MOD_MUL_P_BUSY_EN
      ,
      .busy   (busy)
`endif
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] e;
   } vec_t;

   int unsigned  n_chk = 0;
   int unsigned  n_pass = 0;
   logic [W-1:0] exp_q[$];
   string        nm_q[$];

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [2*W-1:0] pr;
      logic [2*W-1:0] m;
      pr = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      m  = pr % {{W{1'b0}}, P};
      return m[W-1:0];
   endfunction

   function automatic logic [W-1:0] ref_inv(input logic [W-1:0] a);
      logic [W-1:0] r;
      logic [W-1:0] base;
      logic [W-1:0] e;
      r    = 1;
      base = a;
      e    = P - 2;
      for (int i = 0; i < int'(W); i++) begin
         if (e[i]) r = ref_mul(r, base);
         base = ref_mul(base, base);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom())};
      return r;
   endfunction

   // scoreboard: every done pulse pops and checks one expectation
   always @(negedge clk) begin
      if (rstn && done) begin
         if (exp_q.size() == 0) begin
            chk("spurious_done", W'(done), '0);
         end else begin
            chk(nm_q.pop_front(), out_c, exp_q.pop_front());
         end
      end
   end

   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e, input string nm);
      @(negedge clk);
      in_a   = a;
      in_b   = b;
      datain = 1'b1;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      @(negedge clk);
      datain = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int k;
      k = 0;
      while (!done && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!done) begin
         chk({nm, "_timeout"}, W'(done), W'(1));
         if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(nm_q.pop_front());
         end
      end
      @(negedge clk);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e, input string nm);
      start(a, b, e, nm);
      wait_done(nm);
   endtask

   initial begin
      vec_t         vecs[11];
      logic [W-1:0] ones;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] first;
      logic         flag;

      ones = '1;
      vecs[0]  = '{a: '0,         b: 256'd99,  e: '0};
      vecs[1]  = '{a: 256'd123,   b: P,        e: '0};
      vecs[2]  = '{a: P - 1,      b: P - 1,    e: 256'd1};
      vecs[3]  = '{a: P,          b: 256'd5,   e: '0};
      vecs[4]  = '{a: ones,       b: 256'd1,   e: MAXR};
      vecs[5]  = '{a: 256'd2,     b: 256'd3,   e: 256'd6};
      vecs[6]  = '{a: P + 1,      b: 256'd7,   e: 256'd7};
      vecs[7]  = '{a: P - 1,      b: 256'd2,   e: P - 2};
      vecs[8]  = '{a: ones,       b: ones,     e: ref_mul(MAXR, MAXR)};
      vecs[9]  = '{a: 256'd1,     b: ones,     e: MAXR};
      vecs[10] = '{a: W'(1) << 255, b: 256'd2, e: MAXR + 1};

      #1;
      chk("reset_out_c", out_c, '0);
      chk("reset_done", W'(done), '0);
`ifdef MOD_MUL_P_BUSY_EN
      chk("reset_busy", W'(busy), '0);
`endif
      #20;
      @(negedge clk);
      rstn = 1'b1;

      // identity with exact done timing
      start(256'd1, 256'd1, 256'd1, "identity");
      flag = 1'b0;
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk);
         if (done) flag = 1'b1;
`ifdef MOD_MUL_P_BUSY_EN
         if (i == 100) chk("busy_in_run", W'(busy), W'(1));
`endif
      end
      chk("identity_done_early", W'(flag), '0);
      @(negedge clk);
      chk("identity_done_at_257", W'(done), W'(1));
      @(negedge clk);
      chk("identity_done_after", W'(done), '0);
`ifdef MOD_MUL_P_BUSY_EN
      chk("busy_idle", W'(busy), '0);
`endif

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].e, $sformatf("vec%0d", i));
      end

      // second strobe while busy must be ignored
      a     = 256'h1234_5678_9ABC_DEF0_0FED_CBA9;
      b     = P - 256'd77;
      first = ref_mul(a, b);
      start(a, b, first, "ignore_first");
      for (int i = 0; i < 99; i++) @(negedge clk);
      in_a   = 256'd3;
      in_b   = 256'd4;
      datain = 1'b1;
      @(negedge clk);
      datain = 1'b0;
      wait_done("ignore_first");
      flag = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) flag = 1'b1;
      end
      chk("ignore_no_second_done", W'(flag), '0);
      chk("ignore_out_c_held", out_c, first);

      // reset mid-operation aborts with no done pulse
      start(256'd11, 256'd13, 256'd143, "aborted");
      for (int i = 0; i < 49; i++) @(negedge clk);
      rstn = 1'b0;
      exp_q.delete();
      nm_q.delete();
      #1;
      chk("abort_out_c", out_c, '0);
      chk("abort_done", W'(done), '0);
`ifdef MOD_MUL_P_BUSY_EN
      chk("abort_busy", W'(busy), '0);
`endif
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      flag = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done) flag = 1'b1;
      end
      chk("abort_no_done", W'(flag), '0);
      run_op(256'd11, 256'd13, 256'd143, "restart");

      for (int i = 0; i < 50; i++) begin
         a = rand_w() % P;
         if (a == '0) a = 256'd1;
         run_op(a, ref_inv(a), 256'd1, $sformatf("inv%0d", i));
      end
      for (int i = 0; i < 50; i++) begin
         a = rand_w();
         b = rand_w();
         run_op(a, b, ref_mul(a, b), $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
